x9_seq_ctrl: RTL and testbench
==============================

Name: x9_seq_ctrl

Overview:
Parametrised program-sequencing and run-control unit for the X9 core. It replaces the fixed PC, the branch ROM LUT and the top-level flag registers with one block. The block adds:
- a req/done run handshake
- a programmable branch-target LUT
- signed relative jumps
- halt detection
- a cycle counter
It sits between instruction decode/ALU and instr_ROM, drives prog_ctr, and gates architectural writes through run.

Parameters:
D, 12, program counter width (instruction memory is 2^D words)
LUT_AW, 4, branch LUT index width (2^LUT_AW entries, each D bits)
CW, 16, cycle counter width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset)
req  input  1  run request, level; 4-phase handshake with done
start_pc  input  D  PC loaded at run start
halt  input  1  decoded halt instruction in current cycle
branch  input  1  decoded branch instruction (taken if one_q=1)
lut_idx  input  LUT_AW  branch LUT index (instruction immediate)
rel_en  input  1  relative jump instruction
rel_off  input  D  signed two's-complement jump offset
lut_wr_en  input  1  LUT write strobe
lut_wr_addr  input  LUT_AW  LUT write index
lut_wr_data  input  D  LUT write data
sc_o, pari, one  input  1 each  current ALU flag outputs
sc_clr, sc_en  input  1 each  shift/carry register control
prog_ctr  output  D  current program counter
sc_q, pari_q, one_q  output  1 each  lagging flag registers
run  output  1  core may commit (gate RegWrite/MemWrite with it)
done  output  1  run finished
cycles  output  CW  RUN-state cycle count of current/last run

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; prog_ctr, cycles, sc_q, pari_q, one_q = 0; run=0, done=0.
  - All LUT entries = 0.
  - Reset mid-run aborts immediately; no partial state survives.
- FSM states: IDLE, RUN, DONE (registered; run = state==RUN, done = state==DONE).
- IDLE:
  - On req=1: prog_ctr<=start_pc, cycles<=0, flags<=0, next=RUN.
  - Otherwise hold all outputs.
- RUN, every cycle:
  - req=0: abort, next=IDLE. prog_ctr, cycles and flags hold. done never asserts.
  - Else halt=1: next=DONE. prog_ctr holds (points at halt), cycles increments for this cycle.
  - Else next-PC priority:
    1. branch&&one_q -> lut[lut_idx]
    2. rel_en -> prog_ctr+rel_off, modulo 2^D
    3. else prog_ctr+1, wrapping all-ones -> 0
  - halt beats branch/rel_en when asserted together.
  - cycles increments by 1 and saturates at 2^CW-1 (no wrap).
  - Flag update only while RUN and not aborting:
    - pari_q<=pari, one_q<=one
    - sc_q: sc_clr -> 0 (priority), else sc_en -> sc_o, else hold.
  - In IDLE/DONE all flags hold.
- DONE:
  - done=1 and prog_ctr/cycles/flags held while req=1.
  - req=0 -> IDLE next cycle; done drops that edge.
  - req held high never restarts a run.
- Branch decision uses one_q, the flag registered from the previous instruction. Latency one instruction.
- LUT:
  - Writable in any state.
  - Read is combinational.
  - Write and branch read of the same index in one cycle: branch uses the old entry, new entry visible next cycle.
- Latency: req to first fetch at start_pc is 1 cycle. Halt to done is 1 cycle.

Optional Feature:
- Macro: X9_SEQ_WATCHDOG_EN.
- Defined: when cycles reaches 2^CW-1 in RUN, force next=DONE even without halt. An extra output timeout (1 bit) is set at the same edge, held through DONE, and cleared on entry to RUN or by reset.
- Undefined: no timeout port. cycles saturates and the run continues until halt or abort.

Test Plan:
- Reset low mid-RUN with prog_ctr=0x01F -> prog_ctr=0, run=0, done=0, cycles=0 immediately, without waiting for a clock edge.
- req=1, start_pc=0x010, halt on 4th fetched instruction -> prog_ctr 0x010,0x011,0x012,0x013 held; done=1 one cycle after halt; cycles=4; req=0 -> done=0 next cycle.
- Write lut[3]=0x2A0; prior instruction sets one=1; branch with lut_idx=3 -> next prog_ctr=0x2A0. Repeat with one=0 -> prog_ctr+1.
- rel_en with rel_off=0xFFE (-2) at prog_ctr=0x005 -> 0x003. At prog_ctr=0xFFF, sequential step -> 0x000.
- Same cycle lut_wr_en to index 5 (0x100) and taken branch via index 5 (old 0x080) -> jump to 0x080. Next taken branch via 5 -> 0x100.
- Watchdog (CW=4, X9_SEQ_WATCHDOG_EN): never halt -> DONE and timeout=1 when cycles=15. req deasserted in RUN without watchdog -> IDLE, done stays 0.

Source files
------------

// File: rtl/x9_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// x9_seq_ctrl_if
// Bundles the run handshake, instruction-decode controls, LUT write port, ALU
// flag inputs and the sequencer outputs of the X9 program sequencer.
//   master : the core side (decode/ALU/run controller); drives requests,
//            decoded controls and flags, observes prog_ctr/run/done/cycles.
//   slave  : the sequencer itself (x9_seq_ctrl).
// Optional: when X9_SEQ_WATCHDOG_EN is defined a 'timeout' output is added.
// -----------------------------------------------------------------------------
interface x9_seq_ctrl_if #(
  parameter int D      = 12,
  parameter int LUT_AW = 4,
  parameter int CW     = 16
);
  // run handshake
  logic                req;
  logic [D-1:0]        start_pc;
  logic                run;
  logic                done;
  logic [CW-1:0]       cycles;
  // decoded instruction controls
  logic                halt;
  logic                branch;
  logic [LUT_AW-1:0]   lut_idx;
  logic                rel_en;
  logic signed [D-1:0] rel_off;
  // branch LUT write port
  logic                lut_wr_en;
  logic [LUT_AW-1:0]   lut_wr_addr;
  logic [D-1:0]        lut_wr_data;
  // ALU flags and shift/carry control
  logic                sc_o;
  logic                pari;
  logic                one;
  logic                sc_clr;
  logic                sc_en;
  // sequencer outputs
  logic [D-1:0]        prog_ctr;
  logic                sc_q;
  logic                pari_q;
  logic                one_q;
`ifdef X9_SEQ_WATCHDOG_EN
  logic                timeout;
`endif

  modport master (
    output req, start_pc, halt, branch, lut_idx, rel_en, rel_off,
           lut_wr_en, lut_wr_addr, lut_wr_data, sc_o, pari, one, sc_clr, sc_en,
    input  prog_ctr, sc_q, pari_q, one_q, run, done, cycles
`ifdef X9_SEQ_WATCHDOG_EN
    , input timeout
`endif
  );

  modport slave (
    input  req, start_pc, halt, branch, lut_idx, rel_en, rel_off,
           lut_wr_en, lut_wr_addr, lut_wr_data, sc_o, pari, one, sc_clr, sc_en,
    output prog_ctr, sc_q, pari_q, one_q, run, done, cycles
`ifdef X9_SEQ_WATCHDOG_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/x9_seq_ctrl.sv
// -----------------------------------------------------------------------------
// x9_seq_ctrl
// Program-sequencing and run-control unit for the X9 core: program counter,
// programmable branch-target LUT, signed relative jumps, halt detection,
// req/done run handshake, RUN-cycle counter and the lagging flag registers.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset (0 = reset), synchronous release
//   bus   : x9_seq_ctrl_if.slave (handshake, decode controls, LUT write port,
//           flags in, prog_ctr/flags/run/done/cycles out)
//
// Optional feature macro: X9_SEQ_WATCHDOG_EN
//   defined   : a run whose cycle count reaches 2^CW-1 is forced to DONE and
//               bus.timeout is raised (cleared on the next run start / reset).
//   undefined : no timeout; the counter saturates and the run continues.
// -----------------------------------------------------------------------------
module x9_seq_ctrl #(
  parameter int D      = 12,
  parameter int LUT_AW = 4,
  parameter int CW     = 16
) (
  input  logic         clk,
  input  logic         reset,
  x9_seq_ctrl_if.slave bus
);

  localparam int            LUT_N   = 1 << LUT_AW;
  localparam logic [CW-1:0] CYC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [D-1:0]  pc;
  logic [D-1:0]  next_pc;
  logic [CW-1:0] cycles;
  logic          run_q;
  logic          done_q;
  logic          sc_q;
  logic          pari_q;
  logic          one_q;
  logic [D-1:0]  lut [LUT_N];
`ifdef X9_SEQ_WATCHDOG_EN
  logic          timeout_q;
`endif

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CYC_MAX) ? v : v + CW'(1);
  endfunction

  // PC-relative target, modulo 2^D. The offset is sign-extended by one bit so
  // the sum is formed exactly before truncation back to D bits.
  function automatic logic [D-1:0] rel_target(input logic [D-1:0]        cur,
                                              input logic signed [D-1:0] off);
    logic signed [D:0] sum;
    sum = $signed({1'b0, cur}) + $signed({off[D-1], off});
    return sum[D-1:0];
  endfunction

  // Next-PC selection. Branch decision uses one_q, the flag registered from
  // the previous instruction. The LUT read is combinational, so a write to
  // the same entry this cycle is only seen by the following branch.
  always_comb begin
    next_pc = pc + D'(1);
    if (bus.branch && one_q) begin
      next_pc = lut[bus.lut_idx];
    end else if (bus.rel_en) begin
      next_pc = rel_target(pc, bus.rel_off);
    end
  end

  // Run-control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      cycles    <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      sc_q      <= 1'b0;
      pari_q    <= 1'b0;
      one_q     <= 1'b0;
`ifdef X9_SEQ_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            state     <= RUN;
            run_q     <= 1'b1;
            pc        <= bus.start_pc;
            cycles    <= '0;
            sc_q      <= 1'b0;
            pari_q    <= 1'b0;
            one_q     <= 1'b0;
`ifdef X9_SEQ_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (!bus.req) begin
            // Abort: everything except the state freezes, done never rises.
            state <= IDLE;
            run_q <= 1'b0;
          end else begin
            cycles <= sat_inc(cycles);
            pari_q <= bus.pari;
            one_q  <= bus.one;
            if (bus.sc_clr) begin
              sc_q <= 1'b0;
            end else if (bus.sc_en) begin
              sc_q <= bus.sc_o;
            end

            if (bus.halt) begin
              // PC stays on the halt instruction.
              state  <= DONE;
              run_q  <= 1'b0;
              done_q <= 1'b1;
            end
`ifdef X9_SEQ_WATCHDOG_EN
            else if (sat_inc(cycles) == CYC_MAX) begin
              state     <= DONE;
              run_q     <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end
`endif
            else begin
              pc <= next_pc;
            end
          end
        end

        DONE: begin
          // Only a req drop leaves DONE; a held req never restarts a run.
          if (!bus.req) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          run_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Branch-target LUT, writable in any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut[i] <= '0;
      end
    end else if (bus.lut_wr_en) begin
      lut[bus.lut_wr_addr] <= bus.lut_wr_data;
    end
  end

  assign bus.prog_ctr = pc;
  assign bus.cycles   = cycles;
  assign bus.run      = run_q;
  assign bus.done     = done_q;
  assign bus.sc_q     = sc_q;
  assign bus.pari_q   = pari_q;
  assign bus.one_q    = one_q;
`ifdef X9_SEQ_WATCHDOG_EN
  assign bus.timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_x9_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_x9_seq_ctrl
// Self-checking bench for x9_seq_ctrl: directed scenarios followed by random
// instruction streams, compared each cycle against a behavioural model of the
// sequencer written with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_x9_seq_ctrl;

  localparam int D      = 12;
  localparam int LUT_AW = 4;
  localparam int CW     = 4;
  localparam int PC_N   = 1 << D;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam int MAXC   = (1 << CW) - 1;

  logic clk;
  logic reset;

  x9_seq_ctrl_if #(.D(D), .LUT_AW(LUT_AW), .CW(CW)) bus ();

  x9_seq_ctrl #(.D(D), .LUT_AW(LUT_AW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // model state: 0 idle, 1 running, 2 finished
  int m_st;
  int m_pc;
  int m_cyc;
  bit m_sc, m_pari, m_one, m_to;
  int m_lut [LUT_N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cyc = 0;
    m_sc = 0; m_pari = 0; m_one = 0; m_to = 0;
    for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
  endtask

  task automatic clear_in();
    bus.req = 0; bus.start_pc = '0; bus.halt = 0; bus.branch = 0;
    bus.lut_idx = '0; bus.rel_en = 0; bus.rel_off = '0;
    bus.lut_wr_en = 0; bus.lut_wr_addr = '0; bus.lut_wr_data = '0;
    bus.sc_o = 0; bus.pari = 0; bus.one = 0; bus.sc_clr = 0; bus.sc_en = 0;
  endtask

  task automatic compare_all();
    check("prog_ctr", bus.prog_ctr, m_pc);
    check("run",      bus.run,      m_st == 1);
    check("done",     bus.done,     m_st == 2);
    check("cycles",   bus.cycles,   m_cyc);
    check("sc_q",     bus.sc_q,     m_sc);
    check("pari_q",   bus.pari_q,   m_pari);
    check("one_q",    bus.one_q,    m_one);
`ifdef X9_SEQ_WATCHDOG_EN
    check("timeout",  bus.timeout,  m_to);
`endif
  endtask

  // Advance the model by one cycle from the present inputs, clock the DUT,
  // then compare outputs #1 after the edge.
  task automatic step();
    int off;
    case (m_st)
      0: if (bus.req) begin
        m_st = 1; m_pc = int'(bus.start_pc); m_cyc = 0;
        m_sc = 0; m_pari = 0; m_one = 0; m_to = 0;
      end
      1: if (!bus.req) begin
        m_st = 0;
      end else begin
        m_cyc = (m_cyc < MAXC) ? m_cyc + 1 : MAXC;
        if (bus.halt) begin
          m_st = 2;
        end
`ifdef X9_SEQ_WATCHDOG_EN
        else if (m_cyc == MAXC) begin
          m_st = 2; m_to = 1;
        end
`endif
        else if (bus.branch && m_one) begin
          m_pc = m_lut[bus.lut_idx];
        end else if (bus.rel_en) begin
          off = int'($unsigned(bus.rel_off));
          if (off >= PC_N / 2) off = off - PC_N;
          m_pc = ((m_pc + off) % PC_N + PC_N) % PC_N;
        end else begin
          m_pc = (m_pc + 1) % PC_N;
        end
        m_pari = bus.pari;
        m_one  = bus.one;
        if (bus.sc_clr) m_sc = 0;
        else if (bus.sc_en) m_sc = bus.sc_o;
      end
      default: if (!bus.req) m_st = 0;
    endcase
    if (bus.lut_wr_en) m_lut[bus.lut_wr_addr] = int'(bus.lut_wr_data);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clear_in();
    model_reset();
    reset = 1'b0;
    #12;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // Load branch targets while idle.
    bus.lut_wr_en = 1; bus.lut_wr_addr = 4'd3; bus.lut_wr_data = 12'h2A0;
    step();
    bus.lut_wr_addr = 4'd5; bus.lut_wr_data = 12'h080;
    step();
    clear_in();

    // Sequential run, halt on 4th fetched instruction.
    bus.req = 1; bus.start_pc = 12'h010;
    step();
    check("start_pc", bus.prog_ctr, 12'h010);
    repeat (3) step();
    check("seq_pc", bus.prog_ctr, 12'h013);
    bus.halt = 1;
    step();
    check("halt_done", bus.done, 1'b1);
    check("halt_pc", bus.prog_ctr, 12'h013);
    check("halt_cycles", bus.cycles, 4);
    bus.halt = 0;
    step();
    check("done_hold", bus.done, 1'b1);
    bus.req = 0;
    step();
    check("done_drop", bus.done, 1'b0);

    // Taken and not-taken branch through lut[3].
    bus.req = 1; bus.start_pc = 12'h100;
    step();
    bus.one = 1;
    step();
    bus.one = 0; bus.branch = 1; bus.lut_idx = 4'd3;
    step();
    check("branch_taken", bus.prog_ctr, 12'h2A0);
    step();
    check("branch_not_taken", bus.prog_ctr, 12'h2A1);
    bus.branch = 0;

    // Same-cycle write and branch read of lut[5].
    bus.one = 1;
    step();
    bus.branch = 1; bus.lut_idx = 4'd5;
    bus.lut_wr_en = 1; bus.lut_wr_addr = 4'd5; bus.lut_wr_data = 12'h100;
    step();
    check("lut_old_entry", bus.prog_ctr, 12'h080);
    bus.lut_wr_en = 0;
    step();
    check("lut_new_entry", bus.prog_ctr, 12'h100);
    clear_in();
    step();

    // Negative relative jump, then PC wrap.
    bus.req = 1; bus.start_pc = 12'h005;
    step();
    bus.rel_en = 1; bus.rel_off = 12'hFFE;
    step();
    check("rel_neg", bus.prog_ctr, 12'h003);
    clear_in();
    step();
    bus.req = 1; bus.start_pc = 12'hFFF;
    step();
    step();
    check("pc_wrap", bus.prog_ctr, 12'h000);

    // Abort from RUN.
    bus.req = 0;
    step();
    check("abort_run", bus.run, 1'b0);
    check("abort_done", bus.done, 1'b0);
    step();
    check("abort_done_stays", bus.done, 1'b0);

    // Long run without halt: counter saturation (or watchdog).
    bus.req = 1; bus.start_pc = 12'h000;
    step();
    repeat (MAXC + 5) step();
    check("cycles_sat", bus.cycles, MAXC);
`ifdef X9_SEQ_WATCHDOG_EN
    check("wd_done", bus.done, 1'b1);
    check("wd_timeout", bus.timeout, 1'b1);
`else
    check("sat_still_run", bus.run, 1'b1);
`endif
    bus.req = 0;
    step();
    step();

    // Asynchronous reset in the middle of a run.
    bus.req = 1; bus.start_pc = 12'h01F;
    step();
    check("pre_reset_pc", bus.prog_ctr, 12'h01F);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pc", bus.prog_ctr, 12'h000);
    check("async_rst_run", bus.run, 1'b0);
    check("async_rst_done", bus.done, 1'b0);
    check("async_rst_cycles", bus.cycles, 0);
    model_reset();
    clear_in();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // Random instruction streams.
    for (int n = 0; n < 600; n++) begin
      bus.req         = ($urandom_range(0, 24) != 0);
      bus.start_pc    = D'($urandom);
      bus.halt        = ($urandom_range(0, 11) == 0);
      bus.branch      = ($urandom_range(0, 3) == 0);
      bus.lut_idx     = LUT_AW'($urandom);
      bus.rel_en      = ($urandom_range(0, 3) == 0);
      bus.rel_off     = D'($urandom);
      bus.lut_wr_en   = ($urandom_range(0, 3) == 0);
      bus.lut_wr_addr = LUT_AW'($urandom);
      bus.lut_wr_data = D'($urandom);
      bus.sc_o        = 1'($urandom);
      bus.pari        = 1'($urandom);
      bus.one         = 1'($urandom);
      bus.sc_clr      = ($urandom_range(0, 5) == 0);
      bus.sc_en       = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
